// File: rtl/column_slice_sequencer_pkg.sv
// Shared encodings and constants for the raycast column sequencer.
// Angles are carried in 1/16-degree units; cosine table is Q1.8.
package raycast_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_CORRECT,
      ST_DIVIDE,
      ST_OUTPUT
   } seq_state_t;

   localparam int ANGLE_SCALE    = 16;
   localparam int ANGLE_SHIFT    = 4;
   localparam int ANGLE_FULL     = 5760;
   localparam int COS_TBL_FRAC_W = 8;
   localparam int COS_TBL_W      = 9;
   localparam int BETA_W         = 5;
   localparam int DIV_W          = 14;

   // round(256*cos(beta)) for beta = 0..31 degrees
   localparam logic [COS_TBL_W-1:0] COS_TBL [0:31] = '{
      9'd256, 9'd256, 9'd256, 9'd256, 9'd255, 9'd255, 9'd255, 9'd254,
      9'd254, 9'd253, 9'd252, 9'd251, 9'd250, 9'd249, 9'd248, 9'd247,
      9'd246, 9'd245, 9'd243, 9'd242, 9'd241, 9'd239, 9'd237, 9'd236,
      9'd234, 9'd232, 9'd230, 9'd228, 9'd226, 9'd224, 9'd222, 9'd219
   };

endpackage

// File: rtl/column_slice_sequencer_if.sv
// Ray request/response and slice output bundle of the column sequencer.
interface column_slice_sequencer_if #(
   parameter int NUM_COLS = 160,
   parameter int DIST_W   = 13,
   parameter int HEIGHT_W = 7
);
   localparam int COL_W = $clog2(NUM_COLS);

   // valid/ready: a transfer happens on a rising edge where both are 1; the
   // sender holds valid and its payload stable until then. The response path
   // has no ready and is only observed while a request is outstanding.
   logic                ray_req_valid;
   logic                ray_req_ready;
   logic [8:0]          ray_angle;
   logic                ray_rsp_valid;
   logic                ray_rsp_hit;
   logic [DIST_W-1:0]   ray_rsp_dist;
   logic                slice_valid;
   logic                slice_ready;
   logic [COL_W-1:0]    slice_col;
   logic [HEIGHT_W-1:0] slice_height;
   logic                slice_last;

   modport master (
      output ray_req_valid, ray_angle,
      input  ray_req_ready,
      input  ray_rsp_valid, ray_rsp_hit, ray_rsp_dist,
      output slice_valid, slice_col, slice_height, slice_last,
      input  slice_ready
   );

   modport slave (
      input  ray_req_valid, ray_angle,
      output ray_req_ready,
      output ray_rsp_valid, ray_rsp_hit, ray_rsp_dist,
      input  slice_valid, slice_col, slice_height, slice_last,
      output slice_ready
   );
endinterface

// File: rtl/column_slice_sequencer_divider.sv
// Serial restoring divider: one quotient bit per cycle, done pulses once the
// last bit has been produced.
module slice_height_divider #(
   parameter int DIVIDEND_W = 14,
   parameter int DIVISOR_W  = 13
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient
);
   localparam int CNT_W = $clog2(DIVIDEND_W);

   logic [DIVISOR_W:0]    rem_q, rem_shift, rem_next;
   logic [DIVIDEND_W-1:0] quo_q;
   logic [DIVISOR_W-1:0]  div_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  running_q, done_q, fits;

   always_comb begin
      rem_shift = {rem_q[DIVISOR_W-1:0], quo_q[DIVIDEND_W-1]};
      fits      = rem_shift >= {1'b0, div_q};
      rem_next  = fits ? rem_shift - {1'b0, div_q} : rem_shift;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            rem_q     <= '0;
            quo_q     <= dividend;
            div_q     <= divisor;
            cnt_q     <= '0;
            running_q <= 1'b1;
         end else if (running_q) begin
            rem_q <= rem_next;
            quo_q <= {quo_q[DIVIDEND_W-2:0], fits};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
               running_q <= 1'b0;
               done_q    <= 1'b1;
            end
         end
      end
   end

   assign done     = done_q;
   assign quotient = quo_q;
endmodule

// File: rtl/column_slice_sequencer.sv
// Walks the screen columns of one frame: casts a ray per column, corrects the
// returned distance for fish-eye and emits a wall-slice height per column.
module column_slice_sequencer
   import raycast_pkg::*;
#(
   parameter int NUM_COLS   = 160,
   parameter int FOV_DEG    = 60,
   parameter int DIST_W     = 13,
   parameter int FRAC_W     = 8,
   parameter int HEIGHT_W   = 7,
   parameter int MAX_HEIGHT = 120,
   parameter int PROJ_CONST = 8896
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [8:0] player_angle,
   output logic       busy,
   output logic       frame_done,
   output seq_state_t dbg_state,
   column_slice_sequencer_if.master bus
);
   localparam int COL_W    = $clog2(NUM_COLS);
   localparam int STEP     = (FOV_DEG * ANGLE_SCALE + NUM_COLS / 2) / NUM_COLS;
   localparam int HALF_FOV = FOV_DEG * ANGLE_SCALE / 2;
   localparam int BETA_MAX = FOV_DEG / 2;

   function automatic int col_offset(input logic [COL_W-1:0] col);
      return HALF_FOV - int'(col) * STEP;
   endfunction

   function automatic logic [8:0] ray_deg(input logic [8:0] player, input logic [COL_W-1:0] col);
      int a;
      a = int'(player) * ANGLE_SCALE + col_offset(col);
      if (a < 0) a = a + ANGLE_FULL;
      else if (a >= ANGLE_FULL) a = a - ANGLE_FULL;
      return 9'(a >> ANGLE_SHIFT);
   endfunction

   function automatic logic [BETA_W-1:0] beta_deg(input logic [COL_W-1:0] col);
      int o;
      o = col_offset(col);
      if (o < 0) o = -o;
      o = o >> ANGLE_SHIFT;
      if (o > BETA_MAX) o = BETA_MAX;
      return BETA_W'(o);
   endfunction

   seq_state_t            state_q, state_d;
   logic [COL_W-1:0]      col_q;
   logic [8:0]            player_q, ray_angle_q;
   logic [BETA_W-1:0]     beta_q;
   logic [DIST_W-1:0]     dist_q, corrected;
   logic [HEIGHT_W-1:0]   height_q;
   logic                  frame_done_q, last_col, div_start, div_done;
   logic [FRAC_W:0]       cos_val;
   logic [DIST_W+FRAC_W:0] prod;
   logic [DIV_W-1:0]      div_quotient;

   assign last_col = (col_q == COL_W'(NUM_COLS - 1));

   // Fish-eye correction: table is Q1.8, rescaled to Q1.FRAC_W.
   always_comb begin
      cos_val   = (FRAC_W+1)'((int'(COS_TBL[beta_q]) << FRAC_W) >> COS_TBL_FRAC_W);
      prod      = {{(FRAC_W+1){1'b0}}, dist_q} * {{DIST_W{1'b0}}, cos_val};
      corrected = DIST_W'(prod >> FRAC_W);
   end

   always_comb begin
      state_d   = state_q;
      div_start = 1'b0;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_ISSUE;
         ST_ISSUE:    if (bus.ray_req_ready) state_d = ST_WAIT_RSP;
         ST_WAIT_RSP: if (bus.ray_rsp_valid) state_d = bus.ray_rsp_hit ? ST_CORRECT : ST_OUTPUT;
         ST_CORRECT: begin
            if (corrected == '0) begin
               state_d = ST_OUTPUT;
            end else begin
               div_start = 1'b1;
               state_d   = ST_DIVIDE;
            end
         end
         ST_DIVIDE:   if (div_done) state_d = ST_OUTPUT;
         ST_OUTPUT:   if (bus.slice_ready) state_d = last_col ? ST_IDLE : ST_ISSUE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         col_q        <= '0;
         player_q     <= '0;
         ray_angle_q  <= '0;
         beta_q       <= '0;
         dist_q       <= '0;
         height_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (start) begin
               player_q    <= player_angle;
               col_q       <= '0;
               ray_angle_q <= ray_deg(player_angle, '0);
               beta_q      <= beta_deg('0);
            end
            ST_WAIT_RSP: if (bus.ray_rsp_valid) begin
               if (bus.ray_rsp_hit) dist_q   <= bus.ray_rsp_dist;
               else                 height_q <= '0;
            end
            ST_CORRECT: if (corrected == '0) height_q <= HEIGHT_W'(MAX_HEIGHT);
            ST_DIVIDE: if (div_done) begin
               height_q <= (div_quotient > DIV_W'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT)
                                                               : div_quotient[HEIGHT_W-1:0];
            end
            ST_OUTPUT: if (bus.slice_ready) begin
               if (last_col) begin
                  col_q        <= '0;
                  frame_done_q <= 1'b1;
               end else begin
                  col_q       <= col_q + 1'b1;
                  ray_angle_q <= ray_deg(player_q, col_q + 1'b1);
                  beta_q      <= beta_deg(col_q + 1'b1);
               end
            end
            default: ;
         endcase
      end
   end

   slice_height_divider #(
      .DIVIDEND_W (DIV_W),
      .DIVISOR_W  (DIST_W)
   ) u_divider (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend (DIV_W'(PROJ_CONST)),
      .divisor  (corrected),
      .done     (div_done),
      .quotient (div_quotient)
   );

   assign bus.ray_req_valid = (state_q == ST_ISSUE);
   assign bus.ray_angle     = ray_angle_q;
   assign bus.slice_valid   = (state_q == ST_OUTPUT);
   assign bus.slice_col     = col_q;
   assign bus.slice_height  = height_q;
   assign bus.slice_last    = (state_q == ST_OUTPUT) && last_col;
   assign busy              = (state_q != ST_IDLE);
   assign frame_done        = frame_done_q;
   assign dbg_state         = state_q;
endmodule

// File: tb/tb_column_slice_sequencer.sv
// Randomized frame-level bench for column_slice_sequencer against a
// trigonometric reference model of ray angle and slice height.
module tb_column_slice_sequencer;
   import raycast_pkg::*;

   localparam int NUM_COLS = 160;
   localparam int FOV_DEG  = 60;
   localparam int DIST_W   = 13;
   localparam int HEIGHT_W = 7;
   localparam int MAX_H    = 120;
   localparam int PROJ     = 8896;

   logic       clock = 1'b0;
   logic       reset, start;
   logic [8:0] player_angle;
   logic       busy, frame_done;
   seq_state_t dbg_state;

   int n_vec = 0;
   int n_err = 0;
   logic [HEIGHT_W-1:0] exp_q[$];

   column_slice_sequencer_if #(.NUM_COLS(NUM_COLS), .DIST_W(DIST_W), .HEIGHT_W(HEIGHT_W)) bus ();

   column_slice_sequencer dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .player_angle (player_angle),
      .busy         (busy),
      .frame_done   (frame_done),
      .dbg_state    (dbg_state),
      .bus          (bus)
   );

   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference model: screen geometry and projection straight from the rules.
   function automatic int model_offset(input int c);
      int step;
      step = (FOV_DEG * 16 + NUM_COLS / 2) / NUM_COLS;
      return FOV_DEG * 16 / 2 - c * step;
   endfunction

   function automatic int model_angle(input int p, input int c);
      int a;
      a = p * 16 + model_offset(c);
      if (a < 0) a += 5760;
      else if (a >= 5760) a -= 5760;
      return a / 16;
   endfunction

   function automatic int model_height(input bit hit, input int d, input int c);
      int o, beta, cosv, corr, h;
      if (!hit) return 0;
      o = model_offset(c);
      if (o < 0) o = -o;
      beta = o / 16;
      cosv = $rtoi($floor(256.0 * $cos(real'(beta) * 3.14159265358979 / 180.0) + 0.5));
      corr = (d * cosv) / 256;
      if (corr == 0) return MAX_H;
      h = PROJ / corr;
      return (h > MAX_H) ? MAX_H : h;
   endfunction

   task automatic check_reset_zero(input string tag);
      check_val({tag, "_busy"},   busy, 0);
      check_val({tag, "_done"},   frame_done, 0);
      check_val({tag, "_reqv"},   bus.ray_req_valid, 0);
      check_val({tag, "_slv"},    bus.slice_valid, 0);
      check_val({tag, "_last"},   bus.slice_last, 0);
      check_val({tag, "_col"},    bus.slice_col, 0);
      check_val({tag, "_height"}, bus.slice_height, 0);
      check_val({tag, "_angle"},  bus.ray_angle, 0);
   endtask

   function automatic int rand_dist();
      if ($urandom_range(0, 30) == 0) return 0;
      if ($urandom_range(0, 1) == 1) return $urandom_range(1, 400);
      return $urandom_range(0, 8191);
   endfunction

   task automatic do_frame(input int player, input bit directed, input int abort_col);
      int exp_ang, exp_h, lat, k, d;
      bit hit;
      player_angle = 9'(player);
      start = 1'b1;
      tick();
      start = 1'b0;
      player_angle = 9'($urandom_range(0, 359));
      check_val("busy_after_start", busy, 1);
      for (int c = 0; c < NUM_COLS; c++) begin
         for (int i = 0; i < 50 && !bus.ray_req_valid; i++) tick();
         exp_ang = model_angle(player, c);
         check_val($sformatf("req_valid_c%0d", c), bus.ray_req_valid, 1);
         check_val($sformatf("ray_angle_c%0d", c), bus.ray_angle, exp_ang);
         if (player == 0 && c == 0)     check_val("spec_p0_c0_angle", bus.ray_angle, 30);
         if (player == 0 && c == 80)    check_val("spec_p0_c80_angle", bus.ray_angle, 0);
         if (player == 350 && c == 0)   check_val("spec_p350_c0_angle", bus.ray_angle, 20);
         if (player == 10 && c == 159)  check_val("spec_p10_c159_angle", bus.ray_angle, 340);
         if (c == 5) begin
            start = 1'b1;
            player_angle = 9'($urandom_range(0, 359));
            tick();
            start = 1'b0;
            check_val("start_ignored_angle", bus.ray_angle, exp_ang);
         end
         k = $urandom_range(0, 3);
         for (int i = 0; i < k; i++) begin
            bus.ray_rsp_valid = (i == 0);
            bus.ray_rsp_hit   = 1'b1;
            bus.ray_rsp_dist  = 13'($urandom_range(1, 50));
            tick();
            bus.ray_rsp_valid = 1'b0;
            check_val($sformatf("req_hold_valid_c%0d", c), bus.ray_req_valid, 1);
            check_val($sformatf("req_hold_angle_c%0d", c), bus.ray_angle, exp_ang);
         end
         bus.ray_req_ready = 1'b1;
         tick();
         bus.ray_req_ready = 1'b0;
         check_val($sformatf("req_drop_c%0d", c), bus.ray_req_valid, 0);
         if (c == abort_col) begin
            reset = 1'b1;
            tick();
            check_reset_zero("abort");
            reset = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 3; i++) begin
               tick();
               check_val("abort_no_done", frame_done, 0);
               check_val("abort_idle", busy, 0);
            end
            return;
         end
         if (directed && (c <= 2 || c == 80)) begin
            hit = 1'b1;
            d = (c == 1) ? 64 : (c == 2) ? 0 : 100;
         end else begin
            hit = ($urandom_range(0, 4) != 0);
            d = rand_dist();
         end
         repeat ($urandom_range(0, 3)) tick();
         exp_q.push_back(HEIGHT_W'(model_height(hit, d, c)));
         bus.ray_rsp_valid = 1'b1;
         bus.ray_rsp_hit   = hit;
         bus.ray_rsp_dist  = 13'(d);
         tick();
         bus.ray_rsp_valid = 1'b0;
         lat = 0;
         while (!bus.slice_valid && lat < 60) begin
            tick();
            lat++;
         end
         check_val($sformatf("slice_valid_c%0d", c), bus.slice_valid, 1);
         if (!hit) check_val($sformatf("miss_latency_c%0d", c), lat, 0);
         exp_h = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
         if (directed && c == 0)  check_val("spec_c0_height", bus.slice_height, 103);
         if (directed && c == 80) check_val("spec_c80_height", bus.slice_height, 88);
         if (directed && c == 1)  check_val("spec_dist64_height", bus.slice_height, 120);
         if (directed && c == 2)  check_val("spec_dist0_height", bus.slice_height, 120);
         k = (c == 3) ? 5 : $urandom_range(0, 2);
         for (int i = 0; i <= k; i++) begin
            if (i > 0) tick();
            check_val($sformatf("slice_hold_valid_c%0d", c), bus.slice_valid, 1);
            check_val($sformatf("slice_col_c%0d", c), bus.slice_col, c);
            check_val($sformatf("slice_height_c%0d", c), bus.slice_height, exp_h);
            check_val($sformatf("slice_last_c%0d", c), bus.slice_last, (c == NUM_COLS - 1));
         end
         bus.slice_ready = 1'b1;
         tick();
         bus.slice_ready = 1'b0;
         if (c == NUM_COLS - 1) begin
            check_val("frame_done_pulse", frame_done, 1);
            check_val("idle_after_frame", busy, 0);
            tick();
            check_val("frame_done_single", frame_done, 0);
         end else begin
            check_val($sformatf("no_done_c%0d", c), frame_done, 0);
            check_val($sformatf("slice_drop_c%0d", c), bus.slice_valid, 0);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      player_angle = '0;
      bus.ray_req_ready = 1'b0;
      bus.ray_rsp_valid = 1'b0;
      bus.ray_rsp_hit   = 1'b0;
      bus.ray_rsp_dist  = '0;
      bus.slice_ready   = 1'b0;
      tick();
      tick();
      check_reset_zero("reset");
      reset = 1'b0;
      tick();
      check_val("idle_after_reset", busy, 0);

      do_frame(0, 1'b1, -1);
      do_frame(350, 1'b0, 37);
      do_frame(10, 1'b0, -1);
      do_frame($urandom_range(0, 359), 1'b0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
